// File: rtl/stack_pkg.sv
// Opcodes, FSM encoding and operand rules for the data stack.
// Shared by stack_exec and stack_alu.
package stack_pkg;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_PUSH = 4'd1;
  localparam logic [3:0] OP_POP  = 4'd2;
  localparam logic [3:0] OP_DUP  = 4'd3;
  localparam logic [3:0] OP_ADD  = 4'd4;
  localparam logic [3:0] OP_SUB  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_OR   = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_DONE
  } state_t;

  function automatic logic [1:0] ops_needed(
    input logic [3:0] op
  );
    case (op)
      OP_POP, OP_DUP, OP_NOT: return 2'd1;
      OP_ADD, OP_SUB,
      OP_AND, OP_OR:          return 2'd2;
      default:                return 2'd0;
    endcase
  endfunction

  function automatic logic is_push(
    input logic [3:0] op
  );
    return (op == OP_PUSH) || (op == OP_DUP);
  endfunction

  function automatic logic is_binary(
    input logic [3:0] op
  );
    return (op == OP_ADD) || (op == OP_SUB) ||
           (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic is_alu(
    input logic [3:0] op
  );
    return is_binary(op) || (op == OP_NOT);
  endfunction

endpackage

// File: rtl/stack_alu.sv
// Combinational stack ALU: (op, nos, tos) -> result, carry.
// carry is the ADD carry-out or the SUB borrow; 0 otherwise.
module stack_alu
  import stack_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] nos,
  input  logic [WIDTH-1:0] tos,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  assign sum  = {1'b0, nos} + {1'b0, tos};
  assign diff = {1'b0, nos} - {1'b0, tos};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    unique case (1'b1)
      (op == OP_ADD): begin
        result = sum[WIDTH-1:0];
        carry  = sum[WIDTH];
      end
      (op == OP_SUB): begin
        result = diff[WIDTH-1:0];
        carry  = diff[WIDTH];
      end
      (op == OP_AND): result = nos & tos;
      (op == OP_OR):  result = nos | tos;
      (op == OP_NOT): result = ~tos;
      default: ;
    endcase
  end

endmodule

// File: rtl/stack_exec.sv
// Data stack with integrated ALU, IDLE->EXEC->DONE per command.
// Define STACK_ALU_FLAGS_EN to add the z/c/n ALU flag outputs.
module stack_exec
  import stack_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [3:0]                 op,
  input  logic                       op_valid,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       err_clr,
  output logic                       busy,
  output logic                       done,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] depth_cnt,
  output logic                       empty,
  output logic                       full,
  output logic                       err_overflow,
  output logic                       err_underflow
`ifdef STACK_ALU_FLAGS_EN
  ,
  output logic                       flag_z,
  output logic                       flag_c,
  output logic                       flag_n
`endif
);

  localparam int DW = $clog2(DEPTH+1);
  localparam int AW = $clog2(DEPTH);

  state_t           state;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    tos_idx;
  logic [AW-1:0]    nos_idx;
  logic [AW-1:0]    push_idx;
  logic [WIDTH-1:0] tos;
  logic [WIDTH-1:0] nos;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  logic             under;
  logic             over;
  logic             ok;
  logic             exec;

  logic [DW-1:0]    nxt_depth;
  logic [WIDTH-1:0] nxt_top;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;

  assign tos_idx  = AW'(depth_cnt - DW'(1));
  assign nos_idx  = AW'(depth_cnt - DW'(2));
  assign push_idx = AW'(depth_cnt);
  assign tos      = mem[tos_idx];
  assign nos      = mem[nos_idx];

  assign empty = (depth_cnt == '0);
  assign full  = (depth_cnt == DW'(DEPTH));

  assign exec  = (state == S_EXEC);
  assign under = DW'(ops_needed(op_q)) > depth_cnt;
  assign over  = is_push(op_q) && full;
  assign ok    = !under && !over;

  stack_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .op    (op_q),
    .nos   (nos),
    .tos   (tos),
    .result(alu_res),
    .carry (alu_carry)
  );

  always_comb begin
    nxt_depth = depth_cnt;
    nxt_top   = top;
    wr_en     = 1'b0;
    wr_idx    = push_idx;
    wr_data   = data_q;
    if (ok) begin
      unique case (1'b1)
        (op_q == OP_PUSH): begin
          wr_en     = 1'b1;
          nxt_depth = depth_cnt + DW'(1);
          nxt_top   = data_q;
        end
        (op_q == OP_DUP): begin
          wr_en     = 1'b1;
          wr_data   = tos;
          nxt_depth = depth_cnt + DW'(1);
          nxt_top   = tos;
        end
        (op_q == OP_POP): begin
          nxt_depth = depth_cnt - DW'(1);
          nxt_top   = (depth_cnt >= DW'(2)) ? nos : '0;
        end
        is_binary(op_q): begin
          wr_en     = 1'b1;
          wr_idx    = nos_idx;
          wr_data   = alu_res;
          nxt_depth = depth_cnt - DW'(1);
          nxt_top   = alu_res;
        end
        (op_q == OP_NOT): begin
          wr_en     = 1'b1;
          wr_idx    = tos_idx;
          wr_data   = alu_res;
          nxt_top   = alu_res;
        end
        default: ;
      endcase
    end
  end

  // Storage is not reset; writes only land on the EXEC edge.
  always_ff @(posedge clock) begin
    if (exec && wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= S_IDLE;
      op_q          <= OP_NOP;
      data_q        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      top           <= '0;
      depth_cnt     <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      err_overflow  <= (err_overflow & ~err_clr) |
                       (exec & over);
      err_underflow <= (err_underflow & ~err_clr) |
                       (exec & under);
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (op_valid) begin
            op_q   <= op;
            data_q <= push_data;
            busy   <= 1'b1;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          depth_cnt <= nxt_depth;
          top       <= nxt_top;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef STACK_ALU_FLAGS_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag_z <= 1'b0;
      flag_c <= 1'b0;
      flag_n <= 1'b0;
    end else if (exec && ok && is_alu(op_q)) begin
      flag_z <= (alu_res == '0);
      flag_c <= alu_carry;
      flag_n <= alu_res[WIDTH-1];
    end
  end
`endif

endmodule

// File: tb/tb_stack_exec.sv
// Directed bench for stack_exec: vector table plus
// hand sequences for reset abort, hold, overflow, err_clr.
module tb_stack_exec;

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] op;
  logic       op_valid;
  logic [7:0] push_data;
  logic       err_clr;
  logic       busy;
  logic       done;
  logic [7:0] top;
  logic [4:0] depth_cnt;
  logic       empty;
  logic       full;
  logic       err_overflow;
  logic       err_underflow;
`ifdef STACK_ALU_FLAGS_EN
  logic       flag_z;
  logic       flag_c;
  logic       flag_n;
`endif

  stack_exec #(
    .WIDTH(8),
    .DEPTH(16)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .op           (op),
    .op_valid     (op_valid),
    .push_data    (push_data),
    .err_clr      (err_clr),
    .busy         (busy),
    .done         (done),
    .top          (top),
    .depth_cnt    (depth_cnt),
    .empty        (empty),
    .full         (full),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
`ifdef STACK_ALU_FLAGS_EN
    ,
    .flag_z       (flag_z),
    .flag_c       (flag_c),
    .flag_n       (flag_n)
`endif
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  // Issue one command from IDLE; returns at the
  // negedge after the FSM is back in IDLE.
  task automatic issue(
    input  logic [3:0] o,
    input  logic [7:0] d,
    output int         lat
  );
    @(negedge clock);
    op        = o;
    push_data = d;
    op_valid  = 1'b1;
    @(posedge clock);
    #1 op_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      lat++;
      if (lat == 1) chk("busy_exec", 32'(busy), 1);
      if (done) break;
    end
    @(negedge clock);
  endtask

  typedef struct {
    logic [3:0] op;
    logic [7:0] data;
    logic [7:0] top;
    logic [4:0] depth;
    logic       ovf;
    logic       unf;
    logic [2:0] zcn;
  } vec_t;

  vec_t tab[16];
  int   lat;
  int   cnt;
  logic saw;

  initial begin
    tab[0]  = '{4'd1, 8'h05, 8'h05, 5'd1, 0, 0, 3'b000};
    tab[1]  = '{4'd1, 8'h03, 8'h03, 5'd2, 0, 0, 3'b000};
    tab[2]  = '{4'd5, 8'h00, 8'h02, 5'd1, 0, 0, 3'b000};
    tab[3]  = '{4'd2, 8'h00, 8'h00, 5'd0, 0, 0, 3'b000};
    tab[4]  = '{4'd1, 8'hF0, 8'hF0, 5'd1, 0, 0, 3'b000};
    tab[5]  = '{4'd1, 8'h20, 8'h20, 5'd2, 0, 0, 3'b000};
    tab[6]  = '{4'd4, 8'h00, 8'h10, 5'd1, 0, 0, 3'b010};
    tab[7]  = '{4'd8, 8'h00, 8'hEF, 5'd1, 0, 0, 3'b001};
    tab[8]  = '{4'd3, 8'h00, 8'hEF, 5'd2, 0, 0, 3'b001};
    tab[9]  = '{4'd6, 8'h00, 8'hEF, 5'd1, 0, 0, 3'b001};
    tab[10] = '{4'd1, 8'h10, 8'h10, 5'd2, 0, 0, 3'b001};
    tab[11] = '{4'd7, 8'h00, 8'hFF, 5'd1, 0, 0, 3'b001};
    tab[12] = '{4'd12, 8'h55, 8'hFF, 5'd1, 0, 0, 3'b001};
    tab[13] = '{4'd2, 8'h00, 8'h00, 5'd0, 0, 0, 3'b001};
    tab[14] = '{4'd2, 8'h00, 8'h00, 5'd0, 0, 1, 3'b001};
    tab[15] = '{4'd1, 8'h01, 8'h01, 5'd1, 0, 1, 3'b001};

    reset     = 1'b0;
    op        = 4'd0;
    op_valid  = 1'b0;
    push_data = 8'h00;
    err_clr   = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("rst_depth", 32'(depth_cnt), 0);
    chk("rst_top", 32'(top), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_err", {30'd0, err_overflow, err_underflow}, 0);
`ifdef STACK_ALU_FLAGS_EN
    chk("rst_flags", {29'd0, flag_z, flag_c, flag_n}, 0);
`endif

    // Reset asserted while PUSH 0x12 is in EXEC.
    op        = 4'd1;
    push_data = 8'h12;
    op_valid  = 1'b1;
    @(posedge clock);
    #1 op_valid = 1'b0;
    @(negedge clock);
    chk("abort_busy_pre", 32'(busy), 1);
    reset = 1'b0;
    #1;
    chk("abort_depth", 32'(depth_cnt), 0);
    chk("abort_top", 32'(top), 0);
    chk("abort_busy", 32'(busy), 0);
    @(negedge clock);
    reset = 1'b1;
    saw   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (done) saw = 1'b1;
    end
    chk("abort_no_done", 32'(saw), 0);
    chk("abort_depth2", 32'(depth_cnt), 0);

    for (int i = 0; i < 16; i++) begin
      issue(tab[i].op, tab[i].data, lat);
      chk($sformatf("v%0d_lat", i), 32'(lat), 2);
      chk($sformatf("v%0d_top", i), 32'(top),
          32'(tab[i].top));
      chk($sformatf("v%0d_depth", i), 32'(depth_cnt),
          32'(tab[i].depth));
      chk($sformatf("v%0d_ovf", i), 32'(err_overflow),
          32'(tab[i].ovf));
      chk($sformatf("v%0d_unf", i), 32'(err_underflow),
          32'(tab[i].unf));
`ifdef STACK_ALU_FLAGS_EN
      chk($sformatf("v%0d_zcn", i),
          {29'd0, flag_z, flag_c, flag_n},
          32'(tab[i].zcn));
`endif
    end

    // ADD with one operand: underflow, stack untouched.
    issue(4'd4, 8'h00, lat);
    chk("unf_add_lat", 32'(lat), 2);
    chk("unf_add_top", 32'(top), 8'h01);
    chk("unf_add_depth", 32'(depth_cnt), 1);
    chk("unf_add_err", 32'(err_underflow), 1);

    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("errclr", 32'(err_underflow), 0);

    // err_clr held across a violating command: set wins.
    @(negedge clock);
    op       = 4'd4;
    op_valid = 1'b1;
    err_clr  = 1'b1;
    @(posedge clock);
    #1 op_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    chk("setwins_done", 32'(done), 1);
    chk("setwins_err", 32'(err_underflow), 1);
    err_clr = 1'b0;
    @(negedge clock);
    chk("setwins_hold", 32'(err_underflow), 1);

    issue(4'd2, 8'h00, lat);
    @(negedge clock);
    err_clr = 1'b1;
    @(negedge clock);
    err_clr = 1'b0;
    chk("pre_hold_depth", 32'(depth_cnt), 0);

    // op_valid held high for 6 edges: two accepts.
    op        = 4'd1;
    push_data = 8'h33;
    op_valid  = 1'b1;
    cnt       = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      if (done) cnt++;
    end
    op_valid = 1'b0;
    @(negedge clock);
    chk("hold_dones", 32'(cnt), 2);
    chk("hold_depth", 32'(depth_cnt), 2);
    chk("hold_top", 32'(top), 8'h33);

    for (int v = 3; v <= 16; v++) begin
      issue(4'd1, 8'(v), lat);
    end
    chk("fill_depth", 32'(depth_cnt), 16);
    chk("fill_full", 32'(full), 1);
    chk("fill_top", 32'(top), 8'h10);
    chk("fill_ovf", 32'(err_overflow), 0);

    issue(4'd1, 8'hAA, lat);
    chk("ovf_lat", 32'(lat), 2);
    chk("ovf_top", 32'(top), 8'h10);
    chk("ovf_depth", 32'(depth_cnt), 16);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_err", 32'(err_overflow), 1);
    chk("ovf_unf", 32'(err_underflow), 0);

    issue(4'd2, 8'h00, lat);
    chk("pop_full_top", 32'(top), 8'h0F);
    chk("pop_full_depth", 32'(depth_cnt), 15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
